com_bus_arbiter_n: RTL

COM_BUS_ARBITER_N -- requirements
Module: com_bus_arbiter_n

---
 rtl/cache_bus_pkg.sv | 21 ++
 rtl/rr_pick.sv | 31 +++
 rtl/com_bus_arbiter_n.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/cache_bus_pkg.sv
// Shared definitions for the coherent bus arbiter and the cache wrappers:
// arbiter state encoding and owner-field layout.
package cache_bus_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GNT_SNOOP = 2'd1,
        GNT_PROC  = 2'd2,
        RELEASE   = 2'd3
    } bus_state_t;

    // Owner field: MSB set marks a snoop owner; the low bits carry the port or core index.
    function automatic int owner_width(input int num_proc);
        return $clog2(num_proc) + 1;
    endfunction

    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: returns the first requester found searching upward
// from last+1, wrapping modulo N.
module rr_pick
    import cache_bus_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = index_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic         valid,
    output logic [W-1:0] index
);

    logic [W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = '0;
        for (int off = N; off >= 1; off--) begin
            cand = W'((int'(last) + off) % N);
            if (req[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/com_bus_arbiter_n.sv
// Common-bus arbiter: fixed-priority snoop write-backs over round-robin
// processor ports, with hold-time revocation and invalidation tracking.
module com_bus_arbiter_n
    import cache_bus_pkg::*;
#(
    parameter  int NUM_CORES = 4,
    parameter  int HOLD_MAX  = 64,
    localparam int NUM_PROC  = 2 * NUM_CORES,
    localparam int OW        = $clog2(NUM_PROC)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PROC-1:0]  Com_Bus_Req_proc,
    output logic [NUM_PROC-1:0]  Com_Bus_Gnt_proc,
    input  logic [NUM_CORES-1:0] Com_Bus_Req_snoop,
    output logic [NUM_CORES-1:0] Com_Bus_Gnt_snoop,
    input  logic                 Invalidate,
    input  logic [NUM_CORES-1:0] Invalidation_done,
    output logic                 All_Invalidation_done,
    output logic                 Bus_busy,
    output logic [OW:0]          Bus_owner,
    output logic                 Bus_timeout
);

    localparam int SW      = index_width(NUM_CORES);
    localparam int HW      = $clog2(HOLD_MAX) + 1;
    localparam int OWNER_W = owner_width(NUM_PROC);

    bus_state_t           state_q, state_d;
    logic [OW-1:0]        last_proc_q;
    logic [OW-1:0]        owner_idx_q;
    logic                 owner_snoop_q;
    logic [HW-1:0]        hold_q;
    logic [NUM_CORES-1:0] done_q;
    logic [NUM_CORES-1:0] ack_mask;
    logic                 timeout_q, timeout_d;
    logic                 rr_valid;
    logic [OW-1:0]        rr_idx;
    logic                 snoop_valid;
    logic [SW-1:0]        snoop_idx;
    logic [SW-1:0]        owner_core;
    logic                 owner_req;
    logic                 hold_expired;
    logic                 data_owner;

    rr_pick #(.N(NUM_PROC)) u_rr_pick (
        .req   (Com_Bus_Req_proc),
        .last  (last_proc_q),
        .valid (rr_valid),
        .index (rr_idx)
    );

    // Snoop write-backs use fixed priority: the lowest core index wins.
    always_comb begin
        snoop_valid = 1'b0;
        snoop_idx   = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (Com_Bus_Req_snoop[SW'(i)]) begin
                snoop_valid = 1'b1;
                snoop_idx   = SW'(i);
            end
        end
    end

    assign owner_core   = owner_idx_q[SW-1:0];
    assign owner_req    = owner_snoop_q ? Com_Bus_Req_snoop[owner_core]
                                        : Com_Bus_Req_proc[owner_idx_q];
    assign hold_expired = (hold_q == HW'(HOLD_MAX - 1));
    assign data_owner   = (state_q == GNT_PROC) && (owner_idx_q < OW'(NUM_CORES));

    always_comb begin
        state_d   = state_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (snoop_valid)
                    state_d = GNT_SNOOP;
                else if (rr_valid)
                    state_d = GNT_PROC;
            end
            GNT_SNOOP, GNT_PROC: begin
                if (!owner_req) begin
                    state_d = RELEASE;
                end else if (hold_expired) begin
                    state_d   = RELEASE;
                    timeout_d = 1'b1;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // last_proc moves only when a processor grant is issued, so a revoked
    // port is already the last one served and loses the next round.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            last_proc_q   <= OW'(NUM_PROC - 1);
            owner_idx_q   <= '0;
            owner_snoop_q <= 1'b0;
            hold_q        <= '0;
            done_q        <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timeout_q <= timeout_d;

            if (state_q == IDLE && state_d == GNT_SNOOP) begin
                owner_snoop_q <= 1'b1;
                owner_idx_q   <= OW'(snoop_idx);
                hold_q        <= '0;
            end else if (state_q == IDLE && state_d == GNT_PROC) begin
                owner_snoop_q <= 1'b0;
                owner_idx_q   <= rr_idx;
                last_proc_q   <= rr_idx;
                hold_q        <= '0;
            end else if (state_d == RELEASE || !Bus_busy) begin
                owner_snoop_q <= 1'b0;
                owner_idx_q   <= '0;
                hold_q        <= '0;
            end else begin
                hold_q <= hold_q + HW'(1);
            end

            if (data_owner && state_d == GNT_PROC && Invalidate)
                done_q <= done_q | Invalidation_done;
            else
                done_q <= '0;
        end
    end

    // The owner's own core never acknowledges its own broadcast, so it is masked in.
    always_comb begin
        ack_mask             = done_q | Invalidation_done;
        ack_mask[owner_core] = 1'b1;
        All_Invalidation_done = data_owner && Invalidate && (&ack_mask);
    end

    always_comb begin
        Com_Bus_Gnt_proc  = '0;
        Com_Bus_Gnt_snoop = '0;
        if (state_q == GNT_PROC)
            Com_Bus_Gnt_proc[owner_idx_q] = 1'b1;
        if (state_q == GNT_SNOOP)
            Com_Bus_Gnt_snoop[owner_core] = 1'b1;
    end

    assign Bus_busy    = (state_q == GNT_SNOOP) || (state_q == GNT_PROC);
    assign Bus_owner   = OWNER_W'({owner_snoop_q, owner_idx_q});
    assign Bus_timeout = timeout_q;

endmodule
